// File: rtl/pattern_detector.sv
// pattern_detector: serial bit-pattern detector with a programmable pattern.
//
// Samples x on every rising clk edge where x_valid is high. Each sample is
// compared, together with the previous PAT_W-1 samples, against the pattern
// register. A hit produces a registered one-cycle pulse on z and bumps a
// saturating match counter.
//
// Parameters
//   PAT_W     pattern length in bits (2..16)
//   PAT_INIT  pattern loaded at reset (MSB = first bit in time)
//   CNT_W     match counter width (1..16)
//
// Ports
//   clk          in   clock, all state changes on its rising edge
//   rst          in   synchronous active-high reset
//   x_valid      in   x carries a valid serial sample this cycle
//   x            in   serial data bit
//   overlap      in   1: overlapping detection, 0: non-overlapping
//   load         in   capture pat_in (and pat_mask_in) into the pattern register
//   pat_in       in   new pattern, MSB is the first bit in time
//   pat_mask_in  in   compare mask, 0 bits are don't-care (mask build only)
//   clr_count    in   clear the match counter
//   z            out  registered match pulse, one cycle after the matching sample
//   match_count  out  saturating number of matches
//   armed        out  the sample window is full (fill == PAT_W)
//
// Build option
//   PATTERN_DETECTOR_MASK_EN  adds pat_mask_in and a per-bit compare mask
//                             (reset value all ones). When undefined every
//                             pattern bit takes part in the compare.

module pattern_detector #(
  parameter int unsigned           PAT_W    = 3,
  parameter logic [PAT_W-1:0]      PAT_INIT = PAT_W'(3'b101),
  parameter int unsigned           CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_valid,
  input  logic             x,
  input  logic             overlap,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
`ifdef PATTERN_DETECTOR_MASK_EN
  input  logic [PAT_W-1:0] pat_mask_in,
`endif
  input  logic             clr_count,
  output logic             z,
  output logic [CNT_W-1:0] match_count,
  output logic             armed
);

  localparam int unsigned      FillW   = $clog2(PAT_W + 1);
  localparam logic [FillW-1:0] FillMax = FillW'(PAT_W);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  // The detection window is PAT_W bits: the PAT_W-1 stored older samples plus
  // the sample arriving this edge. The oldest bit of a full PAT_W-bit shifter
  // would be shifted out before it is ever compared, so it is not stored.
  logic [PAT_W-2:0] history_q, history_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [PAT_W-1:0] mask_q;
  logic [FillW-1:0] fill_q, fill_d;
  logic             z_q, z_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             sample;
  logic [PAT_W-1:0] window;
  logic [FillW-1:0] fill_upd;
  logic             match;

`ifdef PATTERN_DETECTOR_MASK_EN
  logic [PAT_W-1:0] mask_d;

  always_comb begin
    mask_d = mask_q;
    if (load) begin
      mask_d = pat_mask_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '1;
    end else begin
      mask_q <= mask_d;
    end
  end
`else
  assign mask_q = '1;
`endif

  // A load edge discards any sample offered in the same cycle.
  assign sample   = x_valid & ~load;
  assign window   = {history_q, x};
  assign fill_upd = (fill_q == FillMax) ? fill_q : fill_q + 1'b1;
  assign match    = sample && (((window ^ pattern_q) & mask_q) == '0) && (fill_upd == FillMax);

  always_comb begin
    history_d = history_q;
    pattern_d = pattern_q;
    fill_d    = fill_q;
    z_d       = 1'b0;

    if (load) begin
      pattern_d = pat_in;
      fill_d    = '0;
    end else if (sample) begin
      history_d = window[PAT_W-2:0];
      z_d       = match;
      // Non-overlapping mode needs PAT_W fresh samples after every hit.
      fill_d    = (match && !overlap) ? '0 : fill_upd;
    end
  end

  // Clear beats a simultaneous match; the match still shows on z.
  always_comb begin
    count_d = count_q;
    if (clr_count) begin
      count_d = '0;
    end else if (match && (count_q != CntMax)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      history_q <= '0;
      pattern_q <= PAT_INIT;
      fill_q    <= '0;
      z_q       <= 1'b0;
      count_q   <= '0;
    end else begin
      history_q <= history_d;
      pattern_q <= pattern_d;
      fill_q    <= fill_d;
      z_q       <= z_d;
      count_q   <= count_d;
    end
  end

  assign z           = z_q;
  assign match_count = count_q;
  assign armed       = (fill_q == FillMax);

endmodule

// File: tb/tb_pattern_detector.sv
// Testbench for pattern_detector (PAT_W=3, default pattern, CNT_W=2).
// Directed scenarios compare against hand-derived constants; the random
// scenario compares against a queue-based reference model.

module tb_pattern_detector;

  localparam int unsigned PAT_W = 3;
  localparam int unsigned CNT_W = 2;
  localparam logic [2:0]  PAT_INIT = 3'b101;

  logic             clk;
  logic             rst;
  logic             x_valid;
  logic             x;
  logic             overlap;
  logic             load;
  logic [PAT_W-1:0] pat_in;
  logic [PAT_W-1:0] pat_mask_in;
  logic             clr_count;
  logic             z;
  logic [CNT_W-1:0] match_count;
  logic             armed;

  int checks;
  int errors;

  // Reference model state
  bit         samp_m[$];
  logic [2:0] pat_m;
  logic [2:0] mask_m;
  logic       z_m;
  int         cnt_m;

  pattern_detector #(
    .PAT_W    (PAT_W),
    .PAT_INIT (PAT_INIT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .x_valid     (x_valid),
    .x           (x),
    .overlap     (overlap),
    .load        (load),
    .pat_in      (pat_in),
`ifdef PATTERN_DETECTOR_MASK_EN
    .pat_mask_in (pat_mask_in),
`endif
    .clr_count   (clr_count),
    .z           (z),
    .match_count (match_count),
    .armed       (armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model one clock edge from the rules: the last PAT_W valid samples since
  // reset, load or a non-overlapping hit form the window.
  task automatic model_edge(input logic r, xv, xb, ov, ld, input logic [2:0] pin, pmask,
                            input logic cl);
    logic [2:0] win;
    if (r) begin
      samp_m.delete();
      pat_m  = PAT_INIT;
      mask_m = 3'b111;
      z_m    = 1'b0;
      cnt_m  = 0;
    end else begin
      z_m = 1'b0;
      if (ld) begin
        pat_m = pin;
`ifdef PATTERN_DETECTOR_MASK_EN
        mask_m = pmask;
`endif
        samp_m.delete();
      end else if (xv) begin
        samp_m.push_back(xb);
        if (samp_m.size() > 3) void'(samp_m.pop_front());
        if (samp_m.size() == 3) begin
          win = {samp_m[0], samp_m[1], samp_m[2]};
          if (((win ^ pat_m) & mask_m) == 3'b000) begin
            z_m = 1'b1;
            if (!ov) samp_m.delete();
          end
        end
      end
      if (cl) cnt_m = 0;
      else if (z_m && cnt_m < 3) cnt_m = cnt_m + 1;
    end
  endtask

  // Drive one cycle, advance the model, and settle 1 time unit past the edge.
  task automatic step(input logic r, xv, xb, ov, ld, input logic [2:0] pin, pmask,
                      input logic cl);
    rst = r; x_valid = xv; x = xb; overlap = ov; load = ld;
    pat_in = pin; pat_mask_in = pmask; clr_count = cl;
    @(posedge clk);
    model_edge(r, xv, xb, ov, ld, pin, pmask, cl);
    #1;
    rst = 1'b0; x_valid = 1'b0; load = 1'b0; clr_count = 1'b0;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b111, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 3'b000, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b111, 1'b0);
    checks++;
    if (z !== 1'b0 || match_count !== 2'd0 || armed !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: z=%b count=%0d armed=%b, want 0/0/0", z, match_count, armed);
    end
    // first cycle after release, no sample
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b111, 1'b0);
    checks++;
    if (z !== 1'b0 || match_count !== 2'd0 || armed !== 1'b0) begin
      errors++;
      $display("FAIL post_release: z=%b count=%0d armed=%b, want 0/0/0", z, match_count, armed);
    end
  endtask

  task automatic run_stream(input string name, input logic ov, input logic [4:0] exp_z,
                            input int exp_cnt);
    logic [4:0] bits;
    bits = 5'b10101;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, bits[4-i], ov, 1'b0, 3'b000, 3'b111, 1'b0);
      checks++;
      if (z !== exp_z[4-i]) begin
        errors++;
        $display("FAIL %s_z[%0d]: got %b want %b", name, i, z, exp_z[4-i]);
      end
    end
    checks++;
    if (match_count !== CNT_W'(exp_cnt)) begin
      errors++;
      $display("FAIL %s_count: got %0d want %0d", name, match_count, exp_cnt);
    end
  endtask

  task automatic test_overlap();
    run_stream("overlap", 1'b1, 5'b00101, 2);
    checks++;
    if (armed !== 1'b1) begin
      errors++;
      $display("FAIL overlap_armed: got %b want 1", armed);
    end
  endtask

  task automatic test_non_overlap();
    run_stream("nonoverlap", 1'b0, 5'b00100, 1);
    checks++;
    if (armed !== 1'b0) begin
      errors++;
      $display("FAIL nonoverlap_armed: got %b want 0", armed);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 3'b111, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 3'b111, 1'b0);
    for (int i = 0; i < 4; i++) begin
      // x toggles during the gap but is not valid
      step(1'b0, 1'b0, 1'(i), 1'b1, 1'b0, 3'b000, 3'b111, 1'b0);
      checks++;
      if (z !== 1'b0) begin
        errors++;
        $display("FAIL gap_z[%0d]: got %b want 0", i, z);
      end
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 3'b111, 1'b0);
    checks++;
    if (z !== 1'b1) begin
      errors++;
      $display("FAIL gap_final_z: got %b want 1", z);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b111, 1'b0);
    checks++;
    if (z !== 1'b0 || match_count !== 2'd1) begin
      errors++;
      $display("FAIL gap_after: z=%b count=%0d, want 0/1", z, match_count);
    end
  endtask

  task automatic test_load();
    logic [2:0] exp_z;
    logic [2:0] bits;
    exp_z = 3'b001;
    bits  = 3'b110;
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 3'b111, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 3'b111, 1'b0);
    // simultaneous sample 0 would complete 110 if it were not discarded
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b110, 3'b111, 1'b0);
    checks++;
    if (z !== 1'b0 || armed !== 1'b0) begin
      errors++;
      $display("FAIL load_cycle: z=%b armed=%b, want 0/0", z, armed);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, bits[2-i], 1'b1, 1'b0, 3'b000, 3'b111, 1'b0);
      checks++;
      if (z !== exp_z[2-i]) begin
        errors++;
        $display("FAIL load_z[%0d]: got %b want %b", i, z, exp_z[2-i]);
      end
    end
  endtask

  task automatic test_saturate();
    logic [10:0] bits;
    bits = 11'b10101010101;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 1'b1, bits[10-i], 1'b1, 1'b0, 3'b000, 3'b111, 1'b0);
    end
    checks++;
    if (match_count !== 2'd3) begin
      errors++;
      $display("FAIL saturate_count: got %0d want 3", match_count);
    end
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 3'b111, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 3'b111, 1'b1);
    checks++;
    if (z !== 1'b1 || match_count !== 2'd0) begin
      errors++;
      $display("FAIL clr_with_match: z=%b count=%0d, want 1/0", z, match_count);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 3'b111, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 3'b111, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 3'b111, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 3'b111, 1'b0);
    checks++;
    if (z !== 1'b0 || armed !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: z=%b armed=%b, want 0/0", z, armed);
    end
  endtask

`ifdef PATTERN_DETECTOR_MASK_EN
  task automatic test_mask();
    logic [2:0] exp_z;
    exp_z = 3'b001;
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b101, 3'b101, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 3'b111, 1'b0);
      checks++;
      if (z !== exp_z[2-i]) begin
        errors++;
        $display("FAIL mask_z[%0d]: got %b want %b", i, z, exp_z[2-i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic r, xv, xb, ov, ld, cl;
    logic [2:0] pin, pmask;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      r     = ($urandom_range(0, 99) == 0);
      ld    = ($urandom_range(0, 29) == 0);
      cl    = ($urandom_range(0, 24) == 0);
      xv    = ($urandom_range(0, 3) != 0);
      xb    = 1'($urandom);
      ov    = ($urandom_range(0, 3) != 0);
      pin   = 3'($urandom);
      pmask = 3'($urandom) | 3'b100;
      step(r, xv, xb, ov, ld, pin, pmask, cl);
      checks++;
      if (z !== z_m || match_count !== CNT_W'(cnt_m) || armed !== (samp_m.size() == 3)) begin
        errors++;
        $display("FAIL random[%0d]: z=%b count=%0d armed=%b, want %b/%0d/%b", i, z,
                 match_count, armed, z_m, cnt_m, samp_m.size() == 3);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; x_valid = 1'b0; x = 1'b0; overlap = 1'b1; load = 1'b0;
    pat_in = '0; pat_mask_in = '1; clr_count = 1'b0;
    test_reset();
    test_overlap();
    test_non_overlap();
    test_gaps();
    test_load();
    test_saturate();
    test_rst_mid();
`ifdef PATTERN_DETECTOR_MASK_EN
    test_mask();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
